store_size_rmw: RTL

- Store-path counterpart of the load-side byte/halfword extension.
- Takes a register value plus a store size (word/half/byte) and produces the memory write.
- Word stores are written directly. Half and byte stores do read-modify-write: read the aligned word, merge the narrow lane, write the whole word back.
- Sits between the datapath (rt value, ALU address) and the word-wide data memory port. The control unit starts it and waits for done.

---
 rtl/store_size_rmw.sv | 117 +++++++++++
 1 files changed

// File: rtl/store_size_rmw.sv
// rtl/store_size_rmw.sv - store-path size handler: direct word writes, read-modify-write for half/byte
// Merges the narrow lane into the aligned memory word and issues a single write per accepted store.
module store_size_rmw #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]    state;
  logic [CW-1:0] lat_cnt;
  logic          cap_byte;
  logic [1:0]    cap_lane;
  logic [15:0]   cap_wdata;
  logic          req_err;
  logic [31:0]   merged;

  assign req_err = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b00 && addr[1:0] != 2'b00);

  // Little-endian lanes: byte lane n is bits [8n+7:8n], half lane selected by addr[1].
  always_comb begin
    merged = mem_rdata;
    if (cap_byte) begin
      case (cap_lane)
        2'd0:    merged[7:0]   = cap_wdata[7:0];
        2'd1:    merged[15:8]  = cap_wdata[7:0];
        2'd2:    merged[23:16] = cap_wdata[7:0];
        default: merged[31:24] = cap_wdata[7:0];
      endcase
    end else if (cap_lane[1]) begin
      merged[31:16] = cap_wdata;
    end else begin
      merged[15:0] = cap_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      cap_byte  <= 1'b0;
      cap_lane  <= 2'b00;
      cap_wdata <= 16'h0;
      mem_addr  <= 32'h0;
      mem_wr    <= 1'b0;
      mem_wdata <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_addr  <= {addr[31:2], 2'b00};
            cap_byte  <= (size == 2'b10);
            cap_lane  <= addr[1:0];
            cap_wdata <= wdata_in[15:0];
            busy      <= 1'b1;
            if (req_err) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_DONE;
            end else if (size == 2'b00) begin
              mem_wdata <= wdata_in;
              mem_wr    <= 1'b1;
              state     <= ST_WRITE;
            end else begin
              lat_cnt <= CW'(MEM_LAT - 1);
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (lat_cnt == '0) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_WRITE: begin
          mem_wr <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        default: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
